mem_port_arbiter: RTL

Arbitrates the single-port unified instruction/data memory between the IF-stage fetch port and the MEM-stage load/store port of the pipeline. Each granted request is latched, driven onto the memory strobes for exactly one cycle, and answered with a one-cycle `done` pulse plus registered read data. The block sits between the pipeline stages and the memory, and gives the hazard unit per-port stall signals.

---
 rtl/mem_port_arbiter_if.sv | 41 ++++
 rtl/mem_port_arbiter.sv | 112 +++++++++++
 2 files changed

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the pipeline ports, the arbiter and the unified memory.
// The arbiter connects through the slave modport; the pipeline/memory environment uses master.
interface mem_port_arbiter_if #(
    parameter int WORD_LEN    = 32,
    parameter int ADDRESS_LEN = 32
);
    logic                   if_req;
    logic [ADDRESS_LEN-1:0] if_addr;
    logic [WORD_LEN-1:0]    if_rdata;
    logic                   if_done;
    logic                   if_stall;

    logic                   d_req;
    logic                   d_we;
    logic [ADDRESS_LEN-1:0] d_addr;
    logic [WORD_LEN-1:0]    d_wdata;
    logic [WORD_LEN-1:0]    d_rdata;
    logic                   d_done;
    logic                   d_stall;

    logic [ADDRESS_LEN-1:0] mem_adr;
    logic [WORD_LEN-1:0]    mem_write_data;
    logic                   mem_read;
    logic                   mem_write;
    logic [WORD_LEN-1:0]    mem_out;

    logic                   busy;
    logic                   owner;

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_out,
        output if_rdata, if_done, if_stall, d_rdata, d_done, d_stall,
               mem_adr, mem_write_data, mem_read, mem_write, busy, owner
    );

    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_out,
        input  if_rdata, if_done, if_stall, d_rdata, d_done, d_stall,
               mem_adr, mem_write_data, mem_read, mem_write, busy, owner
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one unified memory between the fetch port and the load/store port (IDLE->ACCESS->DONE).
// Define ARB_ROUND_ROBIN_EN for round-robin ties; otherwise the data port always wins ties.
module mem_port_arbiter #(
    parameter int WORD_LEN    = 32,
    parameter int ADDRESS_LEN = 32
) (
    input logic               clk,
    input logic               rst,
    mem_port_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t                 r_state;
    logic [ADDRESS_LEN-1:0] r_adr;
    logic [WORD_LEN-1:0]    r_wdata;
    logic [WORD_LEN-1:0]    r_if_rdata;
    logic [WORD_LEN-1:0]    r_d_rdata;
    logic                   r_we;
    logic                   r_owner;
    logic                   r_mem_read;
    logic                   r_mem_write;
    logic                   r_if_done;
    logic                   r_d_done;
    logic                   w_any_req;
    logic                   w_grant_d;

`ifdef ARB_ROUND_ROBIN_EN
    logic r_last_owner;
`endif

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        w_any_req = bus.if_req | bus.d_req;
        w_grant_d = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
        // A tie goes to whichever port was not granted last.
        if (bus.d_req && (!bus.if_req || !r_last_owner)) w_grant_d = 1'b1;
`else
        if (bus.d_req) w_grant_d = 1'b1;
`endif
    end

    // NOTE: all state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_adr       <= '0;
            r_wdata     <= '0;
            r_if_rdata  <= '0;
            r_d_rdata   <= '0;
            r_we        <= 1'b0;
            r_owner     <= 1'b0;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_if_done   <= 1'b0;
            r_d_done    <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
            r_last_owner <= 1'b1;
`endif
        end else begin
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_if_done   <= 1'b0;
            r_d_done    <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_any_req) begin
                        r_owner     <= w_grant_d;
                        r_adr       <= w_grant_d ? bus.d_addr : bus.if_addr;
                        r_we        <= w_grant_d & bus.d_we;
                        if (w_grant_d) r_wdata <= bus.d_wdata;
                        r_mem_read  <= ~(w_grant_d & bus.d_we);
                        r_mem_write <= w_grant_d & bus.d_we;
`ifdef ARB_ROUND_ROBIN_EN
                        r_last_owner <= w_grant_d;
`endif
                        r_state     <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (!r_we) begin
                        if (r_owner) r_d_rdata  <= bus.mem_out;
                        else         r_if_rdata <= bus.mem_out;
                    end
                    r_if_done <= ~r_owner;
                    r_d_done  <= r_owner;
                    r_state   <= DONE;
                end
                DONE:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.mem_adr        = r_adr;
    assign bus.mem_write_data = r_wdata;
    assign bus.mem_read       = r_mem_read;
    // Reset arriving during ACCESS must not let the store commit on the reset edge.
    assign bus.mem_write      = r_mem_write & ~rst;
    assign bus.if_rdata       = r_if_rdata;
    assign bus.d_rdata        = r_d_rdata;
    assign bus.if_done        = r_if_done;
    assign bus.d_done         = r_d_done;
    assign bus.if_stall       = bus.if_req & ~r_if_done;
    assign bus.d_stall        = bus.d_req & ~r_d_done;
    assign bus.busy           = (r_state != IDLE);
    assign bus.owner          = r_owner;
endmodule
